cmd_stream_arbiter: RTL and testbench

CMD_STREAM_ARBITER -- requirements
Module: cmd_stream_arbiter

---
 rtl/sddt_cmd_pkg.sv | 19 +
 rtl/ref_timer.sv | 65 ++++++
 rtl/cmd_stream_arbiter.sv | 129 ++++++++++++
 tb/tb_cmd_stream_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sddt_cmd_pkg.sv
// Shared definitions for the command-stream arbiter: FSM encoding, default
// refresh command word and the bit layout of the debug "states" word.
package sddt_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOST = 2'd1,
        ST_REF  = 2'd2
    } arb_state_t;

    localparam logic [127:0] REF_CMD_DEFAULT = 128'h0;

    localparam int STATES_FSM_LSB     = 0;
    localparam int STATES_PEND_LSB    = 2;
    localparam int STATES_OVF_BIT     = 6;
    localparam int STATES_REFCNT_LSB  = 8;
    localparam int STATES_HOSTCNT_LSB = 16;

endpackage

// File: rtl/ref_timer.sv
// Refresh interval timer with a saturating pending-refresh counter and a
// sticky overflow flag. inc pulses on each timer wrap; dec consumes one refresh.
module ref_timer #(
    parameter int REF_INTERVAL = 7800,
    parameter int MAX_POSTPONE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ref_en,
    input  logic       dec,
    output logic       inc,
    output logic [3:0] pending,
    output logic       overflow
);

    localparam logic [15:0] TIMER_LAST = 16'(REF_INTERVAL - 1);
    localparam logic [3:0]  PEND_MAX   = 4'(MAX_POSTPONE);

    logic [15:0] timer_reg, timer_next;
    logic [3:0]  pending_reg, pending_next;
    logic        overflow_reg, overflow_next;
    logic        wrap;

    assign wrap = ref_en && (timer_reg == TIMER_LAST);

    // Disabling the timer parks it at zero but leaves queued refreshes alone.
    always_comb begin
        timer_next = timer_reg + 16'd1;
        if (!ref_en || wrap) begin
            timer_next = '0;
        end
    end

    // A wrap and a drain in the same cycle cancel out.
    always_comb begin
        pending_next  = pending_reg;
        overflow_next = overflow_reg;
        if (wrap && !dec) begin
            if (pending_reg >= PEND_MAX) begin
                overflow_next = 1'b1;
            end else begin
                pending_next = pending_reg + 4'd1;
            end
        end else if (dec && !wrap && (pending_reg != 4'd0)) begin
            pending_next = pending_reg - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_reg    <= '0;
            pending_reg  <= '0;
            overflow_reg <= 1'b0;
        end else begin
            timer_reg    <= timer_next;
            pending_reg  <= pending_next;
            overflow_reg <= overflow_next;
        end
    end

    assign inc      = wrap;
    assign pending  = pending_reg;
    assign overflow = overflow_reg;

endmodule

// File: rtl/cmd_stream_arbiter.sv
// Merges the host command stream with periodic refresh commands, never
// splitting a host bundle. Define CMD_ARB_STATS_EN to expose statistics counters.
module cmd_stream_arbiter
    import sddt_cmd_pkg::*;
#(
    parameter int                DATA_W       = 128,
    parameter int                REF_INTERVAL = 7800,
    parameter int                MAX_POSTPONE = 8,
    parameter logic [DATA_W-1:0] REF_CMD      = DATA_W'(REF_CMD_DEFAULT)
) (
    input  logic              axi_aclk,
    input  logic              axi_aresetn,
    input  logic              ref_en,
    input  logic [DATA_W-1:0] S_AXIS_CMD_tdata,
    input  logic              S_AXIS_CMD_tvalid,
    output logic              S_AXIS_CMD_tready,
    input  logic              S_AXIS_CMD_tlast,
    output logic [DATA_W-1:0] M_AXIS_CMD_tdata,
    output logic              M_AXIS_CMD_tvalid,
    input  logic              M_AXIS_CMD_tready,
    output logic [31:0]       states
);

    localparam logic [3:0] PEND_MAX = 4'(MAX_POSTPONE);

    arb_state_t state_reg;
    logic [3:0] pending;
    logic       overflow;
    logic       ref_wrap;
    logic       host_last_hs;
    logic       ref_hs;

    assign host_last_hs = (state_reg == ST_HOST) && S_AXIS_CMD_tvalid
                          && M_AXIS_CMD_tready && S_AXIS_CMD_tlast;
    assign ref_hs       = (state_reg == ST_REF) && M_AXIS_CMD_tready;

    ref_timer #(
        .REF_INTERVAL (REF_INTERVAL),
        .MAX_POSTPONE (MAX_POSTPONE)
    ) u_ref_timer (
        .clk      (axi_aclk),
        .rst_n    (axi_aresetn),
        .ref_en   (ref_en),
        .dec      (ref_hs),
        .inc      (ref_wrap),
        .pending  (pending),
        .overflow (overflow)
    );

    // A saturated refresh backlog outranks the host, but only between bundles.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_reg <= ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pending >= PEND_MAX) begin
                        state_reg <= ST_REF;
                    end else if (S_AXIS_CMD_tvalid) begin
                        state_reg <= ST_HOST;
                    end else if (pending != 4'd0) begin
                        state_reg <= ST_REF;
                    end
                end
                ST_HOST: begin
                    if (host_last_hs) begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_REF: begin
                    if (ref_hs) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Host data passes straight through so a bundle streams at full rate.
    always_comb begin
        M_AXIS_CMD_tdata  = '0;
        M_AXIS_CMD_tvalid = 1'b0;
        S_AXIS_CMD_tready = 1'b0;
        case (state_reg)
            ST_HOST: begin
                M_AXIS_CMD_tdata  = S_AXIS_CMD_tdata;
                M_AXIS_CMD_tvalid = S_AXIS_CMD_tvalid;
                S_AXIS_CMD_tready = M_AXIS_CMD_tready;
            end
            ST_REF: begin
                M_AXIS_CMD_tdata  = REF_CMD;
                M_AXIS_CMD_tvalid = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef CMD_ARB_STATS_EN
    logic [7:0]  ref_cnt_reg;
    logic [15:0] host_cnt_reg;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            ref_cnt_reg  <= '0;
            host_cnt_reg <= '0;
        end else begin
            if (ref_hs) begin
                ref_cnt_reg <= ref_cnt_reg + 8'd1;
            end
            if (host_last_hs) begin
                host_cnt_reg <= host_cnt_reg + 16'd1;
            end
        end
    end
`endif

    always_comb begin
        states = '0;
        states[STATES_FSM_LSB +: 2]  = state_reg;
        states[STATES_PEND_LSB +: 4] = pending;
        states[STATES_OVF_BIT]       = overflow;
`ifdef CMD_ARB_STATS_EN
        states[STATES_REFCNT_LSB +: 8]   = ref_cnt_reg;
        states[STATES_HOSTCNT_LSB +: 16] = host_cnt_reg;
`endif
    end

endmodule

// File: tb/tb_cmd_stream_arbiter.sv
// Directed bench for cmd_stream_arbiter with a 16-cycle refresh interval and
// a postpone ceiling of 2; inputs change and outputs are sampled on negedges.
module tb_cmd_stream_arbiter;

    localparam int                DATA_W       = 32;
    localparam int                REF_INTERVAL = 16;
    localparam int                MAX_POSTPONE = 2;
    localparam logic [DATA_W-1:0] REF_CMD      = 32'hA5A5_0F0F;

    logic              axi_aclk = 1'b0;
    logic              axi_aresetn;
    logic              ref_en;
    logic [DATA_W-1:0] S_AXIS_CMD_tdata;
    logic              S_AXIS_CMD_tvalid;
    logic              S_AXIS_CMD_tready;
    logic              S_AXIS_CMD_tlast;
    logic [DATA_W-1:0] M_AXIS_CMD_tdata;
    logic              M_AXIS_CMD_tvalid;
    logic              M_AXIS_CMD_tready;
    logic [31:0]       states;

    int vectors     = 0;
    int miscompares = 0;

    always #5 axi_aclk = ~axi_aclk;

    cmd_stream_arbiter #(
        .DATA_W       (DATA_W),
        .REF_INTERVAL (REF_INTERVAL),
        .MAX_POSTPONE (MAX_POSTPONE),
        .REF_CMD      (REF_CMD)
    ) dut (
        .axi_aclk          (axi_aclk),
        .axi_aresetn       (axi_aresetn),
        .ref_en            (ref_en),
        .S_AXIS_CMD_tdata  (S_AXIS_CMD_tdata),
        .S_AXIS_CMD_tvalid (S_AXIS_CMD_tvalid),
        .S_AXIS_CMD_tready (S_AXIS_CMD_tready),
        .S_AXIS_CMD_tlast  (S_AXIS_CMD_tlast),
        .M_AXIS_CMD_tdata  (M_AXIS_CMD_tdata),
        .M_AXIS_CMD_tvalid (M_AXIS_CMD_tvalid),
        .M_AXIS_CMD_tready (M_AXIS_CMD_tready),
        .states            (states)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ends with reset released on a negedge (call that negedge N0).
    task automatic do_reset(input logic ref_en_val);
        @(negedge axi_aclk);
        axi_aresetn       = 1'b0;
        ref_en            = 1'b0;
        S_AXIS_CMD_tvalid = 1'b0;
        S_AXIS_CMD_tlast  = 1'b0;
        S_AXIS_CMD_tdata  = '0;
        M_AXIS_CMD_tready = 1'b1;
        @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        ref_en      = ref_en_val;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values with live-looking inputs, then 100 quiet cycles.
        axi_aresetn       = 1'b0;
        ref_en            = 1'b0;
        S_AXIS_CMD_tvalid = 1'b1;
        S_AXIS_CMD_tdata  = 32'h1111_2222;
        S_AXIS_CMD_tlast  = 1'b0;
        M_AXIS_CMD_tready = 1'b1;
        repeat (3) @(negedge axi_aclk);
        chk("rst_m_tvalid", M_AXIS_CMD_tvalid, 0);
        chk("rst_s_tready", S_AXIS_CMD_tready, 0);
        chk("rst_m_tdata", M_AXIS_CMD_tdata, 0);
        chk("rst_states", states, 0);
        S_AXIS_CMD_tvalid = 1'b0;
        axi_aresetn       = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge axi_aclk);
            chk("quiet_states", states, 0);
            chk("quiet_m_tvalid", M_AXIS_CMD_tvalid, 0);
        end

        // Periodic refresh: pending at N16, REF beat at N17, drained at N18.
        do_reset(1'b1);
        for (int b = 0; b < 3; b++) begin
            repeat (b == 0 ? 16 : 14) @(negedge axi_aclk);
            chk("per_pend1", states[7:0], 8'h04);
            chk("per_quiet", M_AXIS_CMD_tvalid, 0);
            @(negedge axi_aclk);
            chk("per_ref_valid", M_AXIS_CMD_tvalid, 1);
            chk("per_ref_data", M_AXIS_CMD_tdata, REF_CMD);
            chk("per_ref_state", states[7:0], 8'h06);
            @(negedge axi_aclk);
            chk("per_drained", states[7:0], 8'h00);
`ifdef CMD_ARB_STATS_EN
            chk("per_ref_count", states[15:8], b + 1);
`else
            chk("per_stats_zero", states[31:8], 0);
`endif
        end

        // 4-beat bundle offered while one refresh is pending.
        do_reset(1'b1);
        repeat (16) @(negedge axi_aclk);
        chk("bnd_pend1", states[7:0], 8'h04);
        S_AXIS_CMD_tvalid = 1'b1;
        S_AXIS_CMD_tdata  = 32'hB000_0001;
        S_AXIS_CMD_tlast  = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge axi_aclk);
            if (i > 1) begin
                S_AXIS_CMD_tdata = 32'hB000_0000 + 32'(i);
                S_AXIS_CMD_tlast = (i == 4);
            end
            #1;
            chk("bnd_valid", M_AXIS_CMD_tvalid, 1);
            chk("bnd_data", M_AXIS_CMD_tdata, 32'hB000_0000 + 32'(i));
            chk("bnd_ready", S_AXIS_CMD_tready, 1);
        end
        chk("bnd_host_pend1", states[7:0], 8'h05);
        @(negedge axi_aclk);
        S_AXIS_CMD_tvalid = 1'b0;
        S_AXIS_CMD_tlast  = 1'b0;
        #1;
        chk("bnd_idle", states[7:0], 8'h04);
        chk("bnd_idle_valid", M_AXIS_CMD_tvalid, 0);
        @(negedge axi_aclk);
        chk("bnd_ref_state", states[7:0], 8'h06);
        chk("bnd_ref_data", M_AXIS_CMD_tdata, REF_CMD);
        @(negedge axi_aclk);
        chk("bnd_drained", states[7:0], 8'h00);

        // Stalled sink: saturation, overflow, wrap coinciding with the REF handshake.
        do_reset(1'b1);
        repeat (16) @(negedge axi_aclk);
        M_AXIS_CMD_tready = 1'b0;
        repeat (4) @(negedge axi_aclk);
        S_AXIS_CMD_tvalid = 1'b1;
        S_AXIS_CMD_tdata  = 32'hC0DE_0001;
        S_AXIS_CMD_tlast  = 1'b1;
        #1;
        chk("stall_valid", M_AXIS_CMD_tvalid, 1);
        chk("stall_data", M_AXIS_CMD_tdata, REF_CMD);
        chk("stall_s_tready", S_AXIS_CMD_tready, 0);
        chk("stall_state", states[7:0], 8'h06);
        repeat (12) @(negedge axi_aclk);
        chk("stall_pend2", states[7:0], 8'h0A);
        repeat (16) @(negedge axi_aclk);
        chk("stall_ovf", states[7:0], 8'h4A);
        chk("stall_data_hold", M_AXIS_CMD_tdata, REF_CMD);
        repeat (15) @(negedge axi_aclk);
        M_AXIS_CMD_tready = 1'b1;
        #1;
        chk("release_valid", M_AXIS_CMD_tvalid, 1);
        chk("release_data", M_AXIS_CMD_tdata, REF_CMD);
        @(negedge axi_aclk);
        chk("coincide_pend", states[7:0], 8'h48);
        chk("coincide_idle_valid", M_AXIS_CMD_tvalid, 0);
        @(negedge axi_aclk);
        chk("second_ref_state", states[7:0], 8'h4A);
        chk("second_ref_data", M_AXIS_CMD_tdata, REF_CMD);
        chk("second_ref_s_tready", S_AXIS_CMD_tready, 0);
        @(negedge axi_aclk);
        chk("second_ref_drained", states[7:0], 8'h44);
        @(negedge axi_aclk);
        chk("host_after_refs", states[7:0], 8'h45);
        chk("host_after_data", M_AXIS_CMD_tdata, 32'hC0DE_0001);
        chk("host_after_valid", M_AXIS_CMD_tvalid, 1);
        chk("host_after_ready", S_AXIS_CMD_tready, 1);
        @(negedge axi_aclk);
        S_AXIS_CMD_tvalid = 1'b0;
        S_AXIS_CMD_tlast  = 1'b0;
        #1;
        chk("stall_end_idle", states[7:0], 8'h44);
`ifdef CMD_ARB_STATS_EN
        chk("stall_ref_count", states[15:8], 2);
        chk("stall_host_count", states[31:16], 1);
`else
        chk("stall_stats_zero", states[31:8], 0);
`endif

        // Reset pulsed during beat 2 of a bundle; beats 3-4 form a new bundle.
        do_reset(1'b0);
        S_AXIS_CMD_tvalid = 1'b1;
        S_AXIS_CMD_tdata  = 32'hD000_0001;
        S_AXIS_CMD_tlast  = 1'b0;
        @(negedge axi_aclk);
        #1;
        chk("mid_beat1_state", states[7:0], 8'h01);
        chk("mid_beat1_data", M_AXIS_CMD_tdata, 32'hD000_0001);
        @(negedge axi_aclk);
        S_AXIS_CMD_tdata = 32'hD000_0002;
        #1;
        chk("mid_beat2_data", M_AXIS_CMD_tdata, 32'hD000_0002);
        axi_aresetn = 1'b0;
        #1;
        chk("mid_rst_m_tvalid", M_AXIS_CMD_tvalid, 0);
        chk("mid_rst_s_tready", S_AXIS_CMD_tready, 0);
        chk("mid_rst_m_tdata", M_AXIS_CMD_tdata, 0);
        chk("mid_rst_states", states, 0);
        @(negedge axi_aclk);
        chk("mid_rst_held", states, 0);
        axi_aresetn      = 1'b1;
        S_AXIS_CMD_tdata = 32'hD000_0003;
        #1;
        chk("post_rst_idle", states, 0);
        chk("post_rst_m_tvalid", M_AXIS_CMD_tvalid, 0);
        @(negedge axi_aclk);
        #1;
        chk("new_beat3_state", states[7:0], 8'h01);
        chk("new_beat3_data", M_AXIS_CMD_tdata, 32'hD000_0003);
        @(negedge axi_aclk);
        S_AXIS_CMD_tdata = 32'hD000_0004;
        S_AXIS_CMD_tlast = 1'b1;
        #1;
        chk("new_beat4_data", M_AXIS_CMD_tdata, 32'hD000_0004);
        chk("new_beat4_ready", S_AXIS_CMD_tready, 1);
        @(negedge axi_aclk);
        S_AXIS_CMD_tvalid = 1'b0;
        S_AXIS_CMD_tlast  = 1'b0;
        #1;
        chk("new_bundle_done", states[7:0], 8'h00);
`ifdef CMD_ARB_STATS_EN
        chk("new_bundle_count", states[31:16], 1);
`else
        chk("new_bundle_stats_zero", states[31:8], 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
